// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported synchronous RAM between the CPU
// datapath (port 0) and an external loader/debug master (port 1).
// Round-robin arbitration, with a bounded lock that lets port 1 keep ownership
// for at most LOCK_MAX consecutive grants while port 0 is waiting.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   reqN, weN, addrN, wdataN       port N command, held until gntN
//   gntN                           port N command accepted this cycle (comb)
//   rvalidN, rdataN                port N read return, one cycle after gntN
//   lock1                          port 1 asks to retain ownership
//   mem_en, mem_we, mem_addr,
//   mem_wdata                      memory command (from the winning port)
//   mem_rdata                      memory read data, one cycle after a read
module mem_port_arbiter #(
    parameter int unsigned AW       = 8,
    parameter int unsigned DW       = 16,
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    input  logic          lock1,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] LOCK_LIM = CW'(LOCK_MAX);

    typedef enum logic {
        IDLE_RR = 1'b0,
        LOCKED  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            last;
    logic            last_next;
    logic [CW-1:0]   lock_cnt;
    logic [CW-1:0]   lock_cnt_next;
    logic [1:0]      rsel;
    logic [1:0]      rsel_next;
    logic            lock_room;

    // State register: lock history, last owner and read-return pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE_RR;
            last     <= 1'b1;
            lock_cnt <= '0;
            rsel     <= '0;
        end else begin
            state    <= state_next;
            last     <= last_next;
            lock_cnt <= lock_cnt_next;
            rsel     <= rsel_next;
        end
    end

    // Arbitration, lock accounting and memory command mux.
    always_comb begin
        gnt0          = 1'b0;
        gnt1          = 1'b0;
        last_next     = last;
        lock_cnt_next = lock_cnt;
        state_next    = state;
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        rsel_next     = '0;

        // In IDLE_RR the count is zero, so the lock always has room there.
        lock_room = (state == IDLE_RR) || (lock_cnt < LOCK_LIM);

        if (!rst) begin
            if (lock1 && req1 && (!req0 || lock_room)) begin
                gnt1 = 1'b1;
            end else if (req0 && req1) begin
                gnt0 = last;
                gnt1 = !last;
            end else if (req0) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end

        if (gnt0) begin
            last_next = 1'b0;
        end else if (gnt1) begin
            last_next = 1'b1;
        end

        // Count only grants that actually keep port 0 waiting; saturate.
        if (!lock1 || gnt0) begin
            lock_cnt_next = '0;
        end else if (gnt1 && req0 && (lock_cnt < LOCK_LIM)) begin
            lock_cnt_next = lock_cnt + CW'(1);
        end

        state_next = (lock_cnt_next != '0) ? LOCKED : IDLE_RR;

        if (gnt0) begin
            mem_en    = 1'b1;
            mem_we    = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (gnt1) begin
            mem_en    = 1'b1;
            mem_we    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end

        rsel_next = {gnt1 & ~we1, gnt0 & ~we0};
    end

    // Read return: a read in flight when reset arrives is never reported.
    assign rvalid0 = rsel[0] & ~rst;
    assign rvalid1 = rsel[1] & ~rst;
    assign rdata0  = mem_rdata;
    assign rdata1  = mem_rdata;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported program/data memory between two requesters.
  - Port 0: the CPU datapath memory interface, i.e. MAR/MBR transfers sequenced by the microcoded control unit.
  - Port 1: an external program loader/debug master.
- Performs round-robin arbitration with a bounded lock for loader bursts, drives the memory command, and routes the one-cycle-latency read return to the owning port.
- Sits between the CPU datapath and the synchronous RAM.

Parameters:
- AW, 8, memory address width (matches MAR width).
- DW, 16, memory data width (matches MBR/IR width).
- LOCK_MAX, 4, maximum consecutive port-1 grants under lock while port 0 is waiting; legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  port 0 access request; held with cmd until gnt0.
- we0  input  1  port 0 write enable (1 = write, 0 = read).
- addr0  input  AW  port 0 address.
- wdata0  input  DW  port 0 write data.
- gnt0  output  1  port 0 command accepted this cycle (combinational).
- rvalid0  output  1  port 0 read data valid (registered).
- rdata0  output  DW  port 0 read data; meaningful only while rvalid0=1.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1  as port 0, for port 1.
- lock1  input  1  port 1 requests retained ownership across consecutive grants.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data, valid one cycle after a read with mem_en=1.

Behaviour:
- Arbitration:
  - Combinational per cycle; at most one gnt high per cycle.
  - gnt = 1 means the memory samples the command at the end of that cycle.
  - mem_en = gnt0|gnt1. mem_we/addr/wdata are muxed from the winner. When idle, mem_we=0 and mem_addr/mem_wdata=0.
  - Back-to-back grants to the same port in consecutive cycles are allowed.
  - The requester presents the next command in the cycle after gnt; req held low means no access.
- Registered state:
  - last: last granted port.
  - lock_cnt: width 4.
  - rsel: 2-bit read-return pipeline.
- Priority, evaluated in order:
  1. lock1=1, req1=1 and (req0=0 or lock_cnt<LOCK_MAX) -> port 1 wins.
  2. Both req asserted -> the port not equal to last wins.
  3. Otherwise the single requester wins.
- last updates on every grant.
- lock_cnt rules:
  - +1 on a gnt1 while lock1=1 and req0=1.
  - Clears on any gnt0.
  - Clears in any cycle with lock1=0.
  - Saturates at LOCK_MAX; never wraps.
- Read return:
  - rsel captures {gnt1&~we1, gnt0&~we0} at each edge.
  - rvalidN = rsel[N] in the following cycle.
  - rdataN = mem_rdata, unregistered passthrough.
  - Writes produce no rvalid.
- Pipelined reads: reads granted in cycles N and N+1 return in N+1 and N+2 respectively, with no bubble.
- Reset (rst=1 at an edge):
  - last=1, so port 0 has first priority after reset.
  - lock_cnt=0, rsel=0.
- While rst=1:
  - gnt0=gnt1=0, mem_en=0, mem_we=0.
  - rvalid0=rvalid1=0, even for a read granted in the cycle before reset.
- Reset mid-burst discards lock history; a read in flight is never reported.
- Requests asserted during reset are arbitrated normally from the first cycle with rst=0.
- Protocol violations (req/cmd changed before gnt) are not detected; the sampled command is whatever is present in the grant cycle.
- Implemented as a two-state machine:
  - IDLE_RR: lock_cnt=0.
  - LOCKED: lock1=1 and lock_cnt>0.
  - Transitions follow the lock_cnt rules above.

Test Plan:
- Solo read: after reset, req0=1, addr0=0x10, we0=0, mem[0x10]=0x0203 in cycle 0 -> gnt0=1, mem_en=1, mem_addr=0x10 in cycle 0; rvalid0=1, rdata0=0x0203 in cycle 1; rvalid1=0 throughout.
- Contention: req0 and req1 held high from cycle 0, lock1=0 -> grants 0,1,0,1 in cycles 0..3; each rvalid follows its grant by exactly one cycle.
- Lock starvation bound: LOCK_MAX=4, req0=req1=lock1=1 from cycle 0 -> gnt1 in cycles 0–3, gnt0 in cycle 4, gnt1 in cycles 5–8, gnt0 in cycle 9.
- Write: req1=1, we1=1, addr1=0xFF, wdata1=0xABCD -> gnt1=1, mem_we=1, mem_addr=0xFF, mem_wdata=0xABCD for one cycle; no rvalid1; a port-0 read of 0xFF issued later returns 0xABCD.
- Reset mid-read: gnt0 read in cycle 5, rst=1 in cycle 6 -> rvalid0=0 in cycle 6; after release with both req high, port 0 is granted first.
- Idle and lock without contention: lock1=1, req1=1, req0=0 for 20 cycles -> gnt1 every cycle and lock_cnt stays 0; then req0 rises -> gnt0 after exactly LOCK_MAX further gnt1 cycles.
